regfile_writeback: RTL

//   Write-back stage directly upstream of the 16-entry register file. Collects results

---
 rtl/regfile_writeback_if.sv | 28 ++
 rtl/regfile_writeback.sv | 83 ++++++++
 2 files changed

// File: rtl/regfile_writeback_if.sv
// Write-back bus: decode issue, ALU and load results in; register file write port and busy mask out.
interface regfile_writeback_if #(
  parameter int DATA_W = 18,
  parameter int ADDR_W = 4
);
  logic                   IssueValid;
  logic [ADDR_W-1:0]      IssueDest;
  logic                   AluValid;
  logic [ADDR_W-1:0]      AluDest;
  logic [DATA_W-1:0]      AluData;
  logic                   MemValid;
  logic                   MemReady;
  logic [ADDR_W-1:0]      MemDest;
  logic [DATA_W-1:0]      MemData;
  logic                   WriteEnable;
  logic [ADDR_W-1:0]      WriteSelect;
  logic [DATA_W-1:0]      WriteData;
  logic [(1<<ADDR_W)-1:0] BusyMask;

  modport master (
    output IssueValid, IssueDest, AluValid, AluDest, AluData, MemValid, MemDest, MemData,
    input  MemReady, WriteEnable, WriteSelect, WriteData, BusyMask
  );
  modport slave (
    input  IssueValid, IssueDest, AluValid, AluDest, AluData, MemValid, MemDest, MemData,
    output MemReady, WriteEnable, WriteSelect, WriteData, BusyMask
  );
endinterface

// File: rtl/regfile_writeback.sv
// Serialises ALU results (priority) and buffered load results onto the single register file
// write port, and tracks destinations that are issued but not yet written.
module regfile_writeback #(
  parameter int DATA_W = 18,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 4
) (
  input logic Clock,
  input logic Clear,
  regfile_writeback_if.slave bus
);
  localparam int NREG  = 1 << ADDR_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] fifoDest [DEPTH];
  logic [DATA_W-1:0] fifoData [DEPTH];
  logic [PTR_W-1:0]  wrPtr, rdPtr;
  logic [CNT_W-1:0]  count;
  logic [NREG-1:0]   busy;

  logic              writeEnable;
  logic [ADDR_W-1:0] writeSelect;
  logic [DATA_W-1:0] writeData;

  logic              memReady, push, pop, launch;
  logic [ADDR_W-1:0] launchDest;
  logic [DATA_W-1:0] launchData;
  logic [NREG-1:0]   setMask, clrMask;

  // Ready depends only on occupancy, so a full FIFO never accepts even while popping.
  assign memReady = Clear && (count < FULL);
  assign push     = bus.MemValid && memReady;
  assign pop      = !bus.AluValid && (count != '0);

  always_comb begin
    launch     = bus.AluValid || pop;
    launchDest = bus.AluValid ? bus.AluDest : fifoDest[rdPtr];
    launchData = bus.AluValid ? bus.AluData : fifoData[rdPtr];
    setMask    = '0;
    clrMask    = '0;
    if (bus.IssueValid) setMask[bus.IssueDest] = 1'b1;
    if (launch)         clrMask[launchDest]    = 1'b1;
  end

  // Payload storage needs no reset; occupancy is governed by the pointers and count.
  always_ff @(posedge Clock) begin
    if (push) begin
      fifoDest[wrPtr] <= bus.MemDest;
      fifoData[wrPtr] <= bus.MemData;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Clear) begin
      wrPtr       <= '0;
      rdPtr       <= '0;
      count       <= '0;
      busy        <= '0;
      writeEnable <= 1'b0;
      writeSelect <= '0;
      writeData   <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
      // A new issue to the register being written wins over the clear.
      busy        <= (busy & ~clrMask) | setMask;
      writeEnable <= launch;
      if (launch) begin
        writeSelect <= launchDest;
        writeData   <= launchData;
      end
    end
  end

  assign bus.MemReady    = memReady;
  assign bus.WriteEnable = writeEnable;
  assign bus.WriteSelect = writeSelect;
  assign bus.WriteData   = writeData;
  assign bus.BusyMask    = busy;
endmodule
